// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dglitch_sync.sv
// Synchronizing deglitch filter: resyncs I into CLK, qualifies new levels for
// FILT_CYCLES enabled cycles, then drives a registered Z with a one-cycle CHG strobe.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_STABLE | Z matches the qualified level, no candidate pending
// ST_QUAL   | s differs from Z, counting persistence of the candidate
module gf180mcu_fd_sc_mcu7t5v0__dglitch_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_CYCLES = 4,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic I,
  input  logic EN,
  output logic Z,
  output logic CHG,
  output logic BUSY,
  inout  wire  VDD,
  inout  wire  VSS
);

  localparam int CW = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(FILT_CYCLES - 1);

  typedef enum logic {ST_STABLE, ST_QUAL} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic                   r_z;
  logic                   w_z_nxt;
  logic                   r_chg;
  logic                   w_chg_nxt;
  logic                   r_busy;
  logic                   w_s;
  logic                   w_unused;

  // Supply pins exist only for cell-level connectivity.
  assign w_unused = ^{VDD, VSS};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], I};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_z_nxt     = r_z;
    w_chg_nxt   = 1'b0;
    case (r_state)
      ST_STABLE: begin
        if (EN && (w_s != r_z)) begin
          if (FILT_CYCLES == 1) begin
            w_z_nxt   = w_s;
            w_chg_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_QUAL;
            w_cnt_nxt   = CW'(1);
          end
        end
      end
      ST_QUAL: begin
        // EN low freezes both the state and the persistence count.
        if (EN) begin
          if (w_s == r_z) begin
            w_state_nxt = ST_STABLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == C_LAST) begin
            w_state_nxt = ST_STABLE;
            w_cnt_nxt   = '0;
            w_z_nxt     = w_s;
            w_chg_nxt   = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_STABLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_STABLE;
      r_cnt   <= '0;
      r_z     <= RST_VAL;
      r_chg   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_z     <= w_z_nxt;
      r_chg   <= w_chg_nxt;
      r_busy  <= (w_state_nxt == ST_QUAL);
    end
  end

  assign Z    = r_z;
  assign CHG  = r_chg;
  assign BUSY = r_busy;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__dglitch_sync.sv
// Bench for the deglitch synchronizer: three parameterizations share one stimulus,
// a persistence-count model checks every cycle, directed literals pin key timings.
module tb_gf180mcu_fd_sc_mcu7t5v0__dglitch_sync;

  localparam int N = 3;
  localparam int SS [N] = '{2, 2, 3};
  localparam int FC [N] = '{4, 4, 1};
  localparam bit RV [N] = '{1'b0, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst;
  logic i_in;
  logic en;
  logic [N-1:0] dz, dchg, dbusy;
  wire vdd = 1'b1;
  wire vss = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu7t5v0__dglitch_sync #(.SYNC_STAGES(SS[0]), .FILT_CYCLES(FC[0]), .RST_VAL(RV[0])) u_d0 (
    .CLK(clk), .RST(rst), .I(i_in), .EN(en), .Z(dz[0]), .CHG(dchg[0]), .BUSY(dbusy[0]), .VDD(vdd), .VSS(vss));
  gf180mcu_fd_sc_mcu7t5v0__dglitch_sync #(.SYNC_STAGES(SS[1]), .FILT_CYCLES(FC[1]), .RST_VAL(RV[1])) u_d1 (
    .CLK(clk), .RST(rst), .I(i_in), .EN(en), .Z(dz[1]), .CHG(dchg[1]), .BUSY(dbusy[1]), .VDD(vdd), .VSS(vss));
  gf180mcu_fd_sc_mcu7t5v0__dglitch_sync #(.SYNC_STAGES(SS[2]), .FILT_CYCLES(FC[2]), .RST_VAL(RV[2])) u_d2 (
    .CLK(clk), .RST(rst), .I(i_in), .EN(en), .Z(dz[2]), .CHG(dchg[2]), .BUSY(dbusy[2]), .VDD(vdd), .VSS(vss));

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: s is I as sampled SYNC_STAGES edges earlier (reset value before that);
  // Z flips once s has disagreed with it on FILT_CYCLES consecutive enabled edges.
  bit m_z [N];
  bit m_chg [N];
  int m_run [N];
  bit ihist [$];
  int ecount;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < N; d++) begin
        m_z[d] = RV[d];
        m_chg[d] = 1'b0;
        m_run[d] = 0;
      end
      ihist.delete();
      ecount = 0;
    end else begin
      for (int d = 0; d < N; d++) begin
        bit s;
        s = (ecount >= SS[d]) ? ihist[ecount - SS[d]] : RV[d];
        m_chg[d] = 1'b0;
        if (en) begin
          if (s == m_z[d]) begin
            m_run[d] = 0;
          end else begin
            m_run[d] = m_run[d] + 1;
            if (m_run[d] == FC[d]) begin
              m_z[d] = s;
              m_chg[d] = 1'b1;
              m_run[d] = 0;
            end
          end
        end
      end
      ihist.push_back(i_in);
      ecount++;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < N; d++) begin
      chk($sformatf("model_z%0d", d), dz[d], m_z[d]);
      chk($sformatf("model_chg%0d", d), dchg[d], m_chg[d]);
      chk($sformatf("model_busy%0d", d), dbusy[d], m_run[d] > 0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int busy_cnt, chg_cnt;

  initial begin
    rst = 1'b1; i_in = 1'b0; en = 1'b1;
    step(3);
    chk("rst_z0", dz[0], 1'b0);
    chk("rst_chg0", dchg[0], 1'b0);
    chk("rst_busy0", dbusy[0], 1'b0);
    chk("rst_z1", dz[1], 1'b1);
    chk("rst_chg1", dchg[1], 1'b0);
    rst = 1'b0;
    step(10);

    // clean rising edge; next posedge is edge m
    i_in = 1'b1;
    step(1); chk("clean_m_busy0", dbusy[0], 1'b0);
    step(1); chk("clean_m1_busy0", dbusy[0], 1'b0);
    step(1); chk("clean_m2_busy0", dbusy[0], 1'b1); chk("clean_m2_z2", dz[2], 1'b0);
    step(1); chk("clean_m3_busy0", dbusy[0], 1'b1); chk("clean_m3_z2", dz[2], 1'b1);
             chk("clean_m3_chg2", dchg[2], 1'b1);   chk("clean_m3_busy2", dbusy[2], 1'b0);
    step(1); chk("clean_m4_busy0", dbusy[0], 1'b1); chk("clean_m4_z0", dz[0], 1'b0);
    step(1); chk("clean_m5_z0", dz[0], 1'b1); chk("clean_m5_chg0", dchg[0], 1'b1);
             chk("clean_m5_busy0", dbusy[0], 1'b0);
    step(1); chk("clean_m6_chg0", dchg[0], 1'b0); chk("clean_m6_z0", dz[0], 1'b1);
    i_in = 1'b0;
    step(10);

    // 3-cycle glitch: rejected
    busy_cnt = 0; chg_cnt = 0;
    i_in = 1'b1;
    for (int k = 0; k < 3; k++) begin step(1); busy_cnt += dbusy[0]; chg_cnt += dchg[0]; end
    i_in = 1'b0;
    for (int k = 0; k < 12; k++) begin step(1); busy_cnt += dbusy[0]; chg_cnt += dchg[0]; end
    chk("glitch3_busy_is3", busy_cnt == 3, 1'b1);
    chk("glitch3_no_chg", chg_cnt == 0, 1'b1);
    chk("glitch3_z0", dz[0], 1'b0);

    // 4-cycle pulse: accepted, Z rises and falls
    busy_cnt = 0; chg_cnt = 0;
    i_in = 1'b1;
    for (int k = 0; k < 4; k++) begin step(1); busy_cnt += dbusy[0]; chg_cnt += dchg[0]; end
    i_in = 1'b0;
    for (int k = 0; k < 12; k++) begin step(1); busy_cnt += dbusy[0]; chg_cnt += dchg[0]; end
    chk("pulse4_two_chg", chg_cnt == 2, 1'b1);
    chk("pulse4_busy_is6", busy_cnt == 6, 1'b1);
    chk("pulse4_z0", dz[0], 1'b0);

    // EN freeze for 5 cycles with cnt=2
    i_in = 1'b1;
    step(4); chk("freeze_m3_busy0", dbusy[0], 1'b1);
    en = 1'b0;
    step(5); chk("freeze_m8_busy0", dbusy[0], 1'b1); chk("freeze_m8_z0", dz[0], 1'b0);
    en = 1'b1;
    step(1); chk("freeze_m9_z0", dz[0], 1'b0); chk("freeze_m9_busy0", dbusy[0], 1'b1);
    step(1); chk("freeze_m10_z0", dz[0], 1'b1); chk("freeze_m10_chg0", dchg[0], 1'b1);
    i_in = 1'b0;
    step(12);

    // async reset mid-qualification (cnt=3)
    i_in = 1'b1;
    step(5); chk("midrst_pre_busy0", dbusy[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy0", dbusy[0], 1'b0);
    chk("midrst_z0", dz[0], 1'b0);
    chk("midrst_chg0", dchg[0], 1'b0);
    chk("midrst_z1", dz[1], 1'b1);
    chk("midrst_busy1", dbusy[1], 1'b0);
    step(2);
    rst = 1'b0;
    step(5); chk("postrst_e4_z0", dz[0], 1'b0);
    step(1); chk("postrst_e5_z0", dz[0], 1'b1); chk("postrst_e5_chg0", dchg[0], 1'b1);
             chk("postrst_z1", dz[1], 1'b1);
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
